// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle RV32M multiply/divide sequencer (shift-add / restoring divide).
// Optional MDU_EARLY_OUT_EN: trivial operations (div-by-zero, overflow, multiply by 0) skip to DONE.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;        // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic              neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic            sgn_a, sgn_b, a_neg, b_neg, dz_in, ovf_in;
  logic [XLEN-1:0] a_mag, b_mag;

  assign sgn_a  = op[2] ? ~op[0] : (op[1:0] != 2'b11);
  assign sgn_b  = op[2] ? ~op[0] : ~op[1];
  assign a_neg  = sgn_a & rs1[XLEN-1];
  assign b_neg  = sgn_b & rs2[XLEN-1];
  assign a_mag  = a_neg ? (~rs1 + 1'b1) : rs1;
  assign b_mag  = b_neg ? (~rs2 + 1'b1) : rs2;
  assign dz_in  = op[2] & (rs2 == '0);
  assign ovf_in = op[2] & ~op[0] & (rs1 == MIN_NEG) & (rs2 == '1);

`ifdef MDU_EARLY_OUT_EN
  logic            early_in;
  logic [XLEN-1:0] early_res;
  assign early_in  = dz_in | ovf_in | (~op[2] & ((rs1 == '0) | (rs2 == '0)));
  assign early_res = dz_in  ? (op[1] ? rs1 : '1) :
                     ovf_in ? (op[1] ? '0 : MIN_NEG) : '0;
`endif

  logic [XLEN-1:0] mul_add;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;

  assign mul_add   = acc_q[0] ? a_q : {XLEN{1'b0}};
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_add};
  assign div_shift = {rem_q, a_q[XLEN-1]};
  // div_diff[XLEN] is the trial-subtract borrow; the invariant rem < divisor keeps it exact
  assign div_diff  = div_shift - {1'b0, b_q};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd, fix_res;

  assign prod = neg_q  ? (~acc_q + 1'b1) : acc_q;
  assign quo  = neg_q  ? (~a_q + 1'b1)   : a_q;
  assign rmd  = rneg_q ? (~rem_q + 1'b1) : rem_q;

  always_comb begin
    fix_res = '0;
    if (op_q[2]) fix_res = op_q[1] ? rmd : quo;
    else         fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    // divide-by-zero remainder already equals rs1 from the restoring loop
    if (dz_q && !op_q[1]) fix_res = '1;
    else if (ovf_q)       fix_res = op_q[1] ? '0 : MIN_NEG;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d    = op;
          a_d     = a_mag;
          b_d     = b_mag;
          acc_d   = {{XLEN{1'b0}}, b_mag};
          rem_d   = '0;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = dz_in;
          ovf_d   = ovf_in;
          cnt_d   = '0;
          state_d = CALC;
`ifdef MDU_EARLY_OUT_EN
          if (early_in) begin
            res_d   = early_res;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (op_q[2]) begin
            rem_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            a_d   = {a_q[XLEN-2:0], ~div_diff[XLEN]};
          end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = FIX;
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          res_d   = fix_res;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q == CALC) || (state_q == FIX);
  assign stall  = busy | (start & (state_q == IDLE));
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: results, latency, stall, flush and reset behaviour.
module tb_mdu_seq;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
                         DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
  localparam int LAT_FULL = 34;
`ifdef MDU_EARLY_OUT_EN
  localparam int LAT_EARLY = 1;
`else
  localparam int LAT_EARLY = 34;
`endif

  logic        clk, rst, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, stall, done;
  logic [31:0] result;

  int total  = 0;
  int passed = 0;

  mdu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Start one operation in the current cycle and follow it to its done pulse.
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int   lat;
    logic st_ok;
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    #1;
    chk({tag, " stall_start"}, 32'(stall), 32'd1);
    lat   = 0;
    st_ok = 1'b1;
    do begin
      step();
      start = 1'b0;
      #1;
      lat++;
      if (!done && !stall) st_ok = 1'b0;
    end while (!done && lat < 60);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    chk({tag, " stall_held"}, 32'(st_ok), 32'd1);
    chk({tag, " stall_done"}, 32'(stall), 32'd0);
    step();
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = MUL; rs1 = '0; rs2 = '0;
    step(); step(); step();
    rst = 1'b0;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'h0);
    chk("reset stall", 32'(stall), 32'd0);

    run("mul 7*-3",       MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_FULL);
    run("mulhu -1*-1",    MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_FULL);
    run("mulh -1*-1",     MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LAT_FULL);
    run("mulhsu -1*2",    MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LAT_FULL);
    run("mul 0*5",        MUL,    32'd0,        32'd5,        32'h00000000, LAT_EARLY);
    run("div ovf",        DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_EARLY);
    run("rem ovf",        REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_EARLY);
    run("div -7/2",       DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_FULL);
    run("rem -7/2",       REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_FULL);
    run("div 7/-2",       DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LAT_FULL);
    run("rem 7/-2",       REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, LAT_FULL);
    run("divu 100/7",     DIVU,   32'd100,      32'd7,        32'd14,       LAT_FULL);
    run("remu 100/7",     REMU,   32'd100,      32'd7,        32'd2,        LAT_FULL);
    run("rem -9/0",       REM,    32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, LAT_EARLY);
    run("divu 5/0",       DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, LAT_EARLY);
    run("remu 5/0",       REMU,   32'd5,        32'd0,        32'd5,        LAT_EARLY);

    // flush together with start in IDLE: start must not be taken
    op = MUL; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush+start busy", 32'(busy), 32'd0);
    step();
    chk("flush+start done", 32'(done), 32'd0);

    // flush at cycle 10 of a DIV
    op = DIV; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    dn = 0;
    for (int c = 1; c < 10; c++) begin
      if (done) dn++;
      step();
    end
    chk("flush busy_c10", 32'(busy), 32'd1);
    if (done) dn++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    if (done) dn++;
    chk("flush busy_c11", 32'(busy), 32'd0);
    chk("flush no_done", 32'(dn), 32'd0);
    chk("flush result_kept", result, 32'd5);
    run("mul after flush", MUL, 32'd3, 32'd5, 32'd15, LAT_FULL);

    // reset at cycle 20 with start held high throughout
    op = MUL; rs1 = 32'd6; rs2 = 32'd7; start = 1'b1;
    for (int c = 0; c < 20; c++) step();
    chk("rst pre busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst result", result, 32'h0);
    begin
      int lat;
      lat = 0;
      do begin
        step();
        lat++;
      end while (!done && lat < 60);
      chk("rst restart latency", 32'(lat), 32'd34);
      chk("rst restart result", result, 32'd42);
      start = 1'b0;
      dn = 0;
      for (int c = 0; c < 5; c++) begin
        step();
        if (done) dn++;
      end
      chk("rst no_extra_done", 32'(dn), 32'd0);
      chk("rst result_held", result, 32'd42);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
